uart_host_bridge: RTL and testbench
===================================

Name: uart_host_bridge

Overview:
CPU-side end of the UART parallel interface. Converts a simple 2-bit-address register bus into the newd/dintx transmit strobe and the donerx/doutrx receive strobe of the UART pair. Buffers both directions in FIFOs, paces transmit bytes against donetx, flags RX overrun and raises a level interrupt. Sits between the processor data bus and the UART top.

Parameters:
FIFO_DEPTH, 8, entries per FIFO; power of 2, minimum 2
DATA_W, 8, byte width; fixed at 8 for the UART

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
addr  input  2  register address: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
wdata  input  8  write data
we  input  1  write strobe, one access per cycle
re  input  1  read strobe; we and re are never both high
rdata  output  8  registered read data
irq  output  1  registered level interrupt
newd  output  1  one-cycle start strobe to the UART transmitter
dintx  output  8  byte to transmit, stable from newd until the next newd
donetx  input  1  one-cycle pulse at the end of a transmitted frame
doutrx  input  8  received byte, valid when donerx=1
donerx  input  1  one-cycle pulse when a byte is received

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: rdata=0, irq=0, newd=0, dintx=0.
  - State: FIFOs empty, CTRL=0, overrun=0, TX FSM in IDLE.
  - Reset mid-frame abandons the frame; no newd is issued until reset is released.
- Register map:
  - DATA write pushes wdata into the TX FIFO. If the TX FIFO is full, the write is dropped silently.
  - DATA read pops the RX FIFO. If the RX FIFO is empty, rdata=0 and nothing is popped.
  - STATUS read bits: [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] rx_overrun (sticky), [5] tx_busy (FSM not IDLE), [7:6]=0.
  - STATUS write: wdata[4]=1 clears rx_overrun. Other bits are ignored.
  - CTRL (read/write) bits: [0] rx_ie, [1] tx_ie, others read 0.
  - Address 3 reads 0; writes to it are ignored.
- Read latency: rdata is updated on the clock edge where re=1 and is valid the following cycle. It holds its value until the next read.
- TX FSM:
  - IDLE -> LOAD when the TX FIFO is non-empty.
  - LOAD: for one cycle, newd=1 and dintx=FIFO head, and the head is popped. Next state is WAIT.
  - WAIT -> IDLE on donetx=1. A donetx seen in IDLE or LOAD is ignored.
  - Minimum spacing between newd pulses: 3 cycles after donetx.
  - First newd comes 2 cycles after a DATA write into an empty FIFO with the FSM in IDLE.
- RX path:
  - donerx=1 pushes doutrx into the RX FIFO.
  - If the FIFO is full, the byte is discarded and rx_overrun is set.
  - If a pop and donerx happen in the same cycle on a full FIFO, both occur and no overrun is flagged.
  - If an overrun-clear and a new overrun happen in the same cycle, rx_overrun stays 1 (set wins).
- FIFOs:
  - Circular buffers with pointers one bit wider than log2(FIFO_DEPTH); pointers wrap naturally.
  - Full and empty flags are derived from the pointers.
  - Simultaneous push and pop on the TX FIFO: both occur, count unchanged. A push on full is dropped even if a pop happens in the same cycle.
- irq, registered: (rx_ie & !rx_empty) | (tx_ie & tx_empty & !tx_busy) | rx_overrun.

Test Plan:
- Reset with writes pending -> all outputs 0, STATUS=0x06, no newd.
- Write 0x41, 0x42, 0x43 to DATA; donetx 10 cycles after each newd -> three newd pulses with dintx=0x41, 0x42, 0x43 in order; STATUS[5]=0 after the last donetx.
- Write 9 bytes with donetx held low -> 8 accepted, tx_full=1 (a newd pop occurs, so confirm the 9th is accepted only if popped first; check count by the sequence of dintx values).
- Pulse donerx with 0x5A then 0xA5; read DATA twice -> rdata=0x5A then 0xA5 one cycle after each re; then STATUS[2]=1.
- 9 donerx pulses without reads -> rx_full=1, rx_overrun=1, irq=1; write STATUS 0x10 -> overrun cleared, FIFO holds the first 8 bytes.
- CTRL=0x02 with TX idle and empty -> irq=1; write DATA -> irq drops once tx_busy=1. Drop rst mid-WAIT -> immediate return to IDLE with outputs 0.

Source files
------------

// File: rtl/uart_host_bridge.sv
// CPU register-bus bridge to the UART parallel strobes: buffers TX/RX bytes in FIFOs,
// paces newd against donetx, keeps a sticky RX overrun flag and drives a registered interrupt.

module uart_host_bridge_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;

    // Callers gate i_push/i_pop against full/empty; the extra pointer bit tells full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
endmodule

module uart_host_bridge #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    input  logic              re,
    output logic [DATA_W-1:0] rdata,
    output logic              irq,
    output logic              newd,
    output logic [DATA_W-1:0] dintx,
    input  logic              donetx,
    input  logic [DATA_W-1:0] doutrx,
    input  logic              donerx,
    output logic [1:0]        o_tx_state
);
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

    tx_state_t         r_tx_state;
    tx_state_t         w_tx_next;
    logic [1:0]        r_ctrl;
    logic              r_overrun;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_dintx;
    logic              r_irq;

    logic              w_tx_push;
    logic              w_tx_pop;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic [DATA_W-1:0] w_tx_head;
    logic              w_rx_push;
    logic              w_rx_pop;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic [DATA_W-1:0] w_rx_head;
    logic              w_tx_busy;
    logic              w_ovr_set;
    logic              w_ovr_clr;
    logic              w_irq_next;
    logic [7:0]        w_status;
    logic [DATA_W-1:0] w_rd_data;

    uart_host_bridge_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_tx_fifo (
        .clk(clk), .rst(rst), .i_push(w_tx_push), .i_din(wdata), .i_pop(w_tx_pop),
        .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
    );

    uart_host_bridge_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_rx_fifo (
        .clk(clk), .rst(rst), .i_push(w_rx_push), .i_din(doutrx), .i_pop(w_rx_pop),
        .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
    );

    assign w_tx_push = we && (addr == ADDR_DATA) && !w_tx_full;
    assign w_rx_pop  = re && (addr == ADDR_DATA) && !w_rx_empty;
    // A same-cycle pop frees the slot, so a full RX FIFO still takes the byte without overrun.
    assign w_rx_push = donerx && (!w_rx_full || w_rx_pop);
    assign w_ovr_set = donerx && w_rx_full && !w_rx_pop;
    assign w_ovr_clr = we && (addr == ADDR_STATUS) && wdata[4];
    assign w_tx_busy = (r_tx_state != TX_IDLE);
    assign w_status  = {2'b00, w_tx_busy, r_overrun, w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};
    assign w_irq_next = (r_ctrl[0] && !w_rx_empty) || (r_ctrl[1] && w_tx_empty && !w_tx_busy) || r_overrun;

    always_comb begin
        w_rd_data = '0;
        case (addr)
            ADDR_DATA:   w_rd_data = w_rx_empty ? '0 : w_rx_head;
            ADDR_STATUS: w_rd_data = w_status;
            ADDR_CTRL:   w_rd_data = {6'b000000, r_ctrl};
            default:     w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_tx_state <= TX_IDLE;
        else      r_tx_state <= w_tx_next;
    end

    // LOAD always follows IDLE with a non-empty FIFO, so its pop never underflows.
    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        newd      = 1'b0;
        case (r_tx_state)
            TX_IDLE: if (!w_tx_empty) w_tx_next = TX_LOAD;
            TX_LOAD: begin
                newd      = 1'b1;
                w_tx_pop  = 1'b1;
                w_tx_next = TX_WAIT;
            end
            TX_WAIT: if (donetx) w_tx_next = TX_IDLE;
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dintx   <= '0;
            r_ctrl    <= '0;
            r_overrun <= 1'b0;
            r_rdata   <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_tx_pop) r_dintx <= w_tx_head;
            if (re) r_rdata <= w_rd_data;
            if (we && (addr == ADDR_CTRL)) r_ctrl <= wdata[1:0];
            if (w_ovr_set)      r_overrun <= 1'b1;
            else if (w_ovr_clr) r_overrun <= 1'b0;
            r_irq <= w_irq_next;
        end
    end

    assign dintx      = (r_tx_state == TX_LOAD) ? w_tx_head : r_dintx;
    assign rdata      = r_rdata;
    assign irq        = r_irq;
    assign o_tx_state = r_tx_state;
endmodule

// File: tb/tb_uart_host_bridge.sv
// Self-checking bench for uart_host_bridge: cycle reference model with byte queues,
// a newd scoreboard and directed plus randomized bus/UART stimulus.

module tb_uart_host_bridge;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic [7:0] rdata;
  logic       irq;
  logic       newd;
  logic [7:0] dintx;
  logic       donetx = 1'b0;
  logic [7:0] doutrx = '0;
  logic       donerx = 1'b0;
  logic [1:0] tx_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_newd = 0;

  // reference model state
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];
  logic [7:0] exp_q[$];
  bit         m_launch, m_inflight, m_ovr, m_irq;
  logic [7:0] m_last_tx, m_rdata;
  logic [1:0] m_ctrl;

  // donetx responder
  bit auto_done = 0;
  bit rand_delay = 0;
  bit tx_noise = 0;
  int done_delay = 10;
  int done_cnt = 0;

  uart_host_bridge #(.FIFO_DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .irq(irq), .newd(newd), .dintx(dintx), .donetx(donetx),
    .doutrx(doutrx), .donerx(donerx), .o_tx_state(tx_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_txq.delete();
    m_rxq.delete();
    exp_q.delete();
    m_launch = 0; m_inflight = 0; m_ovr = 0; m_irq = 0;
    m_last_tx = '0; m_rdata = '0; m_ctrl = '0;
  endtask

  // Applies one clock edge of the register-map / FIFO / pacing rules to the model.
  task automatic model_update();
    int         txn;
    int         rxn;
    bit         busy;
    bit         rx_pop;
    bit         ovr_set;
    bit         irq_n;
    logic [7:0] status;
    if (!rst) begin
      model_reset();
      return;
    end
    txn = m_txq.size();
    rxn = m_rxq.size();
    busy = m_launch || m_inflight;
    status = {2'b00, busy, m_ovr, (rxn == DEPTH), (rxn == 0), (txn == 0), (txn == DEPTH)};
    rx_pop = re && (addr == 2'd0) && (rxn > 0);
    irq_n = (m_ctrl[0] && rxn > 0) || (m_ctrl[1] && txn == 0 && !busy) || m_ovr;
    ovr_set = 0;
    if (re) begin
      case (addr)
        2'd0: m_rdata = rx_pop ? m_rxq.pop_front() : 8'h00;
        2'd1: m_rdata = status;
        2'd2: m_rdata = {6'b0, m_ctrl};
        default: m_rdata = 8'h00;
      endcase
    end
    if (donerx) begin
      if (rxn < DEPTH || rx_pop) m_rxq.push_back(doutrx);
      else ovr_set = 1;
    end
    if (we && addr == 2'd1 && wdata[4]) m_ovr = 0;
    if (ovr_set) m_ovr = 1;
    if (we && addr == 2'd2) m_ctrl = wdata[1:0];
    if (m_launch) begin
      m_last_tx = m_txq.pop_front();
      m_launch = 0;
      m_inflight = 1;
    end else if (m_inflight) begin
      if (donetx) m_inflight = 0;
    end else if (txn > 0) begin
      m_launch = 1;
    end
    if (we && addr == 2'd0 && txn < DEPTH) begin
      m_txq.push_back(wdata);
      exp_q.push_back(wdata);
    end
    m_irq = irq_n;
  endtask

  // One clock cycle: check outputs mid-cycle, run the responder, advance the model at the edge.
  task automatic step();
    logic [7:0] exp_dintx;
    @(negedge clk);
    exp_dintx = m_last_tx;
    if (m_launch) exp_dintx = m_txq[0];
    chk("newd", newd, m_launch);
    chk("dintx", dintx, exp_dintx);
    chk("irq", irq, m_irq);
    chk("rdata", rdata, m_rdata);
    chk("tx_busy_dbg", (tx_state != 2'd0), (m_launch || m_inflight));
    if (newd) begin
      n_newd++;
      chk("tx_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("tx_order", dintx, exp_q.pop_front());
    end
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) donetx = 1'b1;
    end else if (tx_noise && !m_inflight && !m_launch && $urandom_range(0, 3) == 0) begin
      donetx = 1'b1;
    end
    if (newd && auto_done) done_cnt = rand_delay ? int'($urandom_range(1, 12)) : done_delay;
    @(posedge clk);
    model_update();
    #1;
    we = 1'b0; re = 1'b0; donetx = 1'b0; donerx = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
  endtask

  task automatic bus_read(input logic [1:0] a);
    addr = a; re = 1'b1;
    step();
  endtask

  task automatic rx_byte(input logic [7:0] d);
    doutrx = d; donerx = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_newd", newd, 0);
    chk("rst_dintx", dintx, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rdata", rdata, 0);
    model_reset();
    done_cnt = 0;
    bus_write(2'd0, 8'($urandom));
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] rx_b[DEPTH+1];
    int base;
    int r;
    model_reset();

    // reset with writes pending
    idle(2);
    bus_write(2'd0, 8'h77);
    bus_write(2'd0, 8'h78);
    rst = 1'b1;
    idle(3);
    bus_read(2'd1);
    chk("status_reset", rdata, 8'h06);

    // three paced bytes
    auto_done = 1; rand_delay = 0; done_delay = 10;
    base = n_newd;
    bus_write(2'd0, 8'h41);
    bus_write(2'd0, 8'h42);
    bus_write(2'd0, 8'h43);
    idle(45);
    chk("tx3_count", n_newd - base, 3);
    bus_read(2'd1);
    chk("status_not_busy", rdata[5], 0);

    // overfill TX with donetx held low
    auto_done = 0;
    base = n_newd;
    for (int i = 0; i < 9; i++) bus_write(2'd0, 8'($urandom));
    bus_read(2'd1);
    chk("tx_full", rdata[0], 1);
    bus_write(2'd0, 8'hEE);
    donetx = 1'b1;
    step();
    auto_done = 1; rand_delay = 1;
    idle(220);
    chk("tx9_count", n_newd - base, 9);
    bus_read(2'd1);
    chk("tx_drained", rdata[1:0], 2'b10);

    // RX ordering
    rx_byte(8'h5A);
    rx_byte(8'hA5);
    bus_read(2'd0);
    chk("rx_first", rdata, 8'h5A);
    bus_read(2'd0);
    chk("rx_second", rdata, 8'hA5);
    bus_read(2'd1);
    chk("rx_empty", rdata[2], 1);

    // RX overrun
    for (int i = 0; i < DEPTH + 1; i++) begin
      rx_b[i] = 8'($urandom);
      rx_byte(rx_b[i]);
    end
    bus_read(2'd1);
    chk("rx_full_ovr", rdata[4:3], 2'b11);
    idle(1);
    chk("irq_ovr", irq, 1);
    bus_write(2'd1, 8'h10);
    bus_read(2'd1);
    chk("ovr_cleared", rdata[4:3], 2'b01);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(2'd0);
      chk("rx_kept", rdata, rx_b[i]);
    end

    // pop + receive on full FIFO, then clear + overrun in the same cycle
    for (int i = 0; i < DEPTH; i++) rx_byte(8'($urandom));
    addr = 2'd0; re = 1'b1; doutrx = 8'hC3; donerx = 1'b1;
    step();
    bus_read(2'd1);
    chk("pop_push_full", rdata[4:3], 2'b01);
    addr = 2'd1; wdata = 8'h10; we = 1'b1; doutrx = 8'h3C; donerx = 1'b1;
    step();
    bus_read(2'd1);
    chk("ovr_set_wins", rdata[4], 1);
    bus_write(2'd1, 8'h10);
    for (int i = 0; i < DEPTH; i++) bus_read(2'd0);
    chk("rx_last", rdata, 8'hC3);

    // tx interrupt, then reset mid-WAIT
    bus_write(2'd2, 8'h02);
    step();
    chk("irq_txie", irq, 1);
    auto_done = 1; rand_delay = 0; done_delay = 10;
    bus_write(2'd0, 8'h99);
    idle(4);
    chk("irq_busy", irq, 0);
    for (int i = 0; i < 20 && !m_inflight; i++) step();
    chk("reach_wait", m_inflight, 1);
    do_reset();
    idle(3);
    bus_read(2'd1);
    chk("status_after_rst", rdata, 8'h06);
    bus_read(2'd2);
    chk("ctrl_after_rst", rdata, 8'h00);

    // randomized traffic
    auto_done = 1; rand_delay = 1; tx_noise = 1;
    bus_write(2'd2, 8'($urandom_range(0, 3)));
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        addr = 2'($urandom_range(0, 3)); wdata = 8'($urandom); we = 1'b1;
      end else if (r < 6) begin
        addr = 2'($urandom_range(0, 3)); re = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) begin
        doutrx = 8'($urandom); donerx = 1'b1;
      end
      step();
    end
    tx_noise = 0;
    idle(300);
    chk("tx_all_sent", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
